sbox_lookup_sequencer: RTL and testbench

//  Sequences one shared S-box lookup port across the 8 six-bit slices of a 48-bit

---
 rtl/sbox_lookup_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_sbox_lookup_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lookup_sequencer.sv
// -----------------------------------------------------------------------------
// sbox_lookup_sequencer
//
// Purpose:
//   Area-reduced DES round helper. A single external S-box lookup port (S1..S8
//   selected by sb_sel) is time-shared across the eight 6-bit slices of the
//   48-bit key-mixed word. The eight 4-bit results are assembled into the
//   32-bit substitution output that feeds the P-permutation. At most one word
//   is in flight; the block walks IDLE -> RUN -> DONE -> IDLE.
//
// Parameters:
//   LOOKUP_LAT  cycles from sb_sel/sb_in driven to sb_out valid (0 or 1)
//
// Ports:
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block can accept in_data (high only in IDLE)
//   in_data    in   48  key-mixed word; slice k = in_data[47-6k -: 6]
//   sb_sel     out  3   S-box index for the current lookup (0 = S1 .. 7 = S8)
//   sb_in      out  6   6-bit lookup input for S-box sb_sel
//   sb_out     in   4   lookup result, valid LOOKUP_LAT cycles after sb_sel/sb_in
//   out_valid  out  1   out_data valid
//   out_ready  in   1   downstream accepts out_data
//   out_data   out  32  result; S(k+1) nibble at out_data[31-4k -: 4]
//   busy       out  1   high in RUN or DONE
// -----------------------------------------------------------------------------
module sbox_lookup_sequencer #(
    parameter int LOOKUP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic [2:0]  sb_sel,
    output logic [5:0]  sb_in,
    input  logic [3:0]  sb_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // With a registered S-box the result for a lookup arrives one cycle after
    // it is issued, so captures trail issues by one cycle.
    localparam bit LAT_REG = (LOOKUP_LAT == 32'sd1);

    generate
        if ((LOOKUP_LAT != 32'sd0) && (LOOKUP_LAT != 32'sd1)) begin : g_bad_lookup_lat
            $error("sbox_lookup_sequencer: LOOKUP_LAT must be 0 or 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Return 6-bit slice idx of the word; slice 0 sits at the MSB end.
    function automatic logic [5:0] slice_f(input logic [47:0] word,
                                           input logic [2:0]  idx);
        logic [47:0] shifted;
        shifted = word << ({3'b000, idx} * 6'd6);
        return shifted[47:42];
    endfunction

    // Replace nibble idx of data (nibble 0 at the MSB end) with nib.
    function automatic logic [31:0] put_nibble_f(input logic [31:0] data,
                                                 input logic [2:0]  idx,
                                                 input logic [3:0]  nib);
        logic [31:0] mask;
        logic [31:0] val;
        mask = 32'hF000_0000 >> ({2'b00, idx} * 5'd4);
        val  = {nib, 28'h000_0000} >> ({2'b00, idx} * 5'd4);
        return (data & ~mask) | val;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]  state_q,     state_d;
    logic [47:0] word_q,      word_d;
    // Issue count runs 0..8; bit 3 set means all eight lookups have been issued.
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  cap_idx_q,   cap_idx_d;
    // Set in the cycle after a lookup was issued; only meaningful when LAT_REG.
    logic        pend_q,      pend_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q,  in_ready_d;
    logic        busy_q,      busy_d;

    logic        issuing_s;
    logic        cap_en_s;

    // Issue qualifier and capture strobe; sb_out is looked at only when cap_en_s.
    always_comb begin
        issuing_s = (state_q == ST_RUN) && !issue_cnt_q[3];
        if (LAT_REG) begin
            cap_en_s = (state_q == ST_RUN) && pend_q;
        end else begin
            cap_en_s = issuing_s;
        end
    end

    // Lookup port drive: current slice while issuing, zero otherwise.
    always_comb begin
        sb_sel = 3'd0;
        sb_in  = 6'd0;
        if (issuing_s) begin
            sb_sel = issue_cnt_q[2:0];
            sb_in  = slice_f(word_q, issue_cnt_q[2:0]);
        end else begin
            sb_sel = 3'd0;
            sb_in  = 6'd0;
        end
    end

    // Next-state logic for the FSM, counters and result register.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        issue_cnt_d = issue_cnt_q;
        cap_idx_d   = cap_idx_q;
        pend_d      = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // New word: previous result is dropped so stale nibbles
                    // never show through during RUN.
                    word_d      = in_data;
                    issue_cnt_d = 4'd0;
                    cap_idx_d   = 3'd0;
                    out_data_d  = 32'h0000_0000;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (issuing_s) begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end else begin
                    issue_cnt_d = issue_cnt_q;
                end
                pend_d = issuing_s;

                if (cap_en_s) begin
                    out_data_d = put_nibble_f(out_data_q, cap_idx_q, sb_out);
                    cap_idx_d  = cap_idx_q + 3'd1;
                    if (cap_idx_q == 3'd7) begin
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                // Result stays frozen until the downstream takes it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle state.
                state_d     = ST_IDLE;
                issue_cnt_d = 4'd0;
                cap_idx_d   = 3'd0;
                out_data_d  = 32'h0000_0000;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset empties the block and discards any
    // partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= 48'h0000_0000_0000;
            issue_cnt_q <= 4'd0;
            cap_idx_q   <= 3'd0;
            pend_q      <= 1'b0;
            out_data_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            issue_cnt_q <= issue_cnt_d;
            cap_idx_q   <= cap_idx_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sbox_lookup_sequencer.sv
`timescale 1ns/1ps
module tb_sbox_lookup_sequencer;

    // DES S-boxes, one 256-bit row-major table each (row*16+col, first nibble at MSB).
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_f(input logic [2:0] k, input logic [5:0] x);
        logic [255:0] t;
        int n;
        t = SBOX_TBL[k];
        n = 16 * int'({x[5], x[0]}) + int'(x[4:1]);
        return t[255 - 4 * n -: 4];
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        lat_sel;
    logic        in_valid;
    logic        out_ready;
    logic [47:0] in_data;

    logic        in_valid0, in_valid1, out_ready0, out_ready1;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [2:0]  sb_sel0, sb_sel1;
    logic [5:0]  sb_in0, sb_in1;
    logic [3:0]  sb_out0, sb_out1;
    logic [31:0] out_data0, out_data1;

    logic        in_ready_m, out_valid_m, busy_m;
    logic [2:0]  sb_sel_m;
    logic [5:0]  sb_in_m;
    logic [31:0] out_data_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees handshakes.
    assign in_valid0  = in_valid  & ~lat_sel;
    assign in_valid1  = in_valid  &  lat_sel;
    assign out_ready0 = out_ready & ~lat_sel;
    assign out_ready1 = out_ready &  lat_sel;

    assign in_ready_m  = lat_sel ? in_ready1  : in_ready0;
    assign out_valid_m = lat_sel ? out_valid1 : out_valid0;
    assign busy_m      = lat_sel ? busy1      : busy0;
    assign sb_sel_m    = lat_sel ? sb_sel1    : sb_sel0;
    assign sb_in_m     = lat_sel ? sb_in1     : sb_in0;
    assign out_data_m  = lat_sel ? out_data1  : out_data0;

    // S-box models: combinational for LAT=0, registered ROM for LAT=1.
    assign sb_out0 = sbox_f(sb_sel0, sb_in0);
    always @(posedge clk) sb_out1 <= sbox_f(sb_sel1, sb_in1);

    sbox_lookup_sequencer #(.LOOKUP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data), .sb_sel(sb_sel0), .sb_in(sb_in0), .sb_out(sb_out0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .busy(busy0)
    );

    sbox_lookup_sequencer #(.LOOKUP_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data), .sb_sel(sb_sel1), .sb_in(sb_in1), .sb_out(sb_out1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (lat=%0d): got %0h expected %0h", tag, lat_sel, got, exp);
        end
    endtask

    // Wait (bounded) at negedges until in_ready is high; next posedge accepts.
    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (in_ready_m !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (in_ready_m === 1'b1);
        if (!ok) check_val("in_ready_timeout", {63'd0, in_ready_m}, 64'd1);
    endtask

    // One word with full cycle-by-cycle checking, then hold DONE for 'hold' cycles.
    task automatic run_word(input logic [47:0] data, input logic [31:0] exp, input int hold);
        int lat;
        bit ok;
        lat = lat_sel ? 1 : 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b0;
        wait_ready(ok);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);               // accept edge
        @(negedge clk);
        in_valid = 1'b0;
        check_val("busy_after_accept", {63'd0, busy_m}, 64'd1);
        check_val("in_ready_after_accept", {63'd0, in_ready_m}, 64'd0);
        check_val("out_data_cleared", {32'd0, out_data_m}, 64'd0);
        for (int k = 0; k < 8 + lat; k++) begin
            if (k < 8) begin
                check_val("sb_sel_seq", {61'd0, sb_sel_m}, 64'(k));
                check_val("sb_in_slice", {58'd0, sb_in_m}, {58'd0, data[47 - 6 * k -: 6]});
            end else begin
                check_val("sb_sel_idle", {61'd0, sb_sel_m}, 64'd0);
            end
            check_val("out_valid_early", {63'd0, out_valid_m}, 64'd0);
            @(negedge clk);
        end
        check_val("out_valid_rise", {63'd0, out_valid_m}, 64'd1);
        check_val("out_data", {32'd0, out_data_m}, {32'd0, exp});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("bp_out_valid", {63'd0, out_valid_m}, 64'd1);
            check_val("bp_out_data", {32'd0, out_data_m}, {32'd0, exp});
            check_val("bp_in_ready", {63'd0, in_ready_m}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("consume_out_valid", {63'd0, out_valid_m}, 64'd0);
        check_val("consume_in_ready", {63'd0, in_ready_m}, 64'd1);
        check_val("consume_busy", {63'd0, busy_m}, 64'd0);
    endtask

    logic [47:0] b2b_data [3] = '{48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h0000_0003_F000};
    logic [31:0] b2b_exp  [3] = '{32'hEFA7_2C4D,      32'hD9CE_3DCB,      32'hEFA7_2D4D};

    // Back-to-back words with in_valid and out_ready held high; checks period.
    task automatic run_b2b();
        int lat;
        int n;
        bit ok;
        time t_acc, t_prev;
        lat = lat_sel ? 1 : 0;
        t_prev = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = b2b_data[0];
        for (int w = 0; w < 3; w++) begin
            wait_ready(ok);
            if (!ok) break;
            @(posedge clk);
            t_acc = $time;
            if (w > 0) check_val("b2b_period", 64'((t_acc - t_prev) / 10), 64'(10 + lat));
            t_prev = t_acc;
            @(negedge clk);
            if (w < 2) in_data = b2b_data[w + 1];
            else       in_valid = 1'b0;
            n = 0;
            while (out_valid_m !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (out_valid_m !== 1'b1) begin
                check_val("out_valid_timeout", {63'd0, out_valid_m}, 64'd1);
                break;
            end
            check_val("b2b_out_data", {32'd0, out_data_m}, {32'd0, b2b_exp[w]});
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        lat_sel   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 48'h0;
        repeat (3) @(negedge clk);
        // Reset state
        for (int s = 0; s < 2; s++) begin
            lat_sel = s[0];
            #1;
            check_val("rst_in_ready", {63'd0, in_ready_m}, 64'd1);
            check_val("rst_out_valid", {63'd0, out_valid_m}, 64'd0);
            check_val("rst_busy", {63'd0, busy_m}, 64'd0);
            check_val("rst_out_data", {32'd0, out_data_m}, 64'd0);
            check_val("rst_sb", {55'd0, sb_sel_m, sb_in_m}, 64'd0);
        end
        lat_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // T1, T2, all-ones, T4 backpressure (LAT=0)
        run_word(48'h0000_0000_0000, 32'hEFA7_2C4D, 0);
        run_word(48'h0000_0003_F000, 32'hEFA7_2D4D, 0);
        run_word(48'hFFFF_FFFF_FFFF, 32'hD9CE_3DCB, 0);
        run_word(48'h0000_0003_F000, 32'hEFA7_2D4D, 5);

        // T5: reset three cycles into RUN
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 48'h0;
        wait_ready(ok);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("partial_nibbles", {32'd0, out_data_m}, {32'd0, 32'hEFA0_0000});
        rst = 1'b1;
        #1;
        check_val("midrun_rst_in_ready", {63'd0, in_ready_m}, 64'd1);
        check_val("midrun_rst_out_valid", {63'd0, out_valid_m}, 64'd0);
        check_val("midrun_rst_out_data", {32'd0, out_data_m}, 64'd0);
        check_val("midrun_rst_busy", {63'd0, busy_m}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("no_pulse_after_rst", {63'd0, out_valid_m}, 64'd0);
        end
        run_word(48'hFFFF_FFFF_FFFF, 32'hD9CE_3DCB, 0);

        // T6 back-to-back, LAT=0
        run_b2b();

        // T3 and friends on LAT=1
        lat_sel = 1'b1;
        run_word(48'h0000_0000_0000, 32'hEFA7_2C4D, 0);
        run_word(48'h0000_0003_F000, 32'hEFA7_2D4D, 3);
        run_b2b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
